// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-boundary registers: control constants, NOP encodings
// and the packed payload layouts carried across IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_stage_reg_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Global stall vector: one bit per pipeline stage plus the write-back slot.
  localparam int unsigned STALL_VEC_W = 6;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_ADD = 8'h01,
    ALU_SUB = 8'h02,
    ALU_AND = 8'h03,
    ALU_OR  = 8'h04,
    ALU_XOR = 8'h05,
    ALU_SLL = 8'h06,
    ALU_SRL = 8'h07
  } alu_op_e;

  localparam alu_op_e alu_op_nop = ALU_NOP;

  // Canonical RV32 NOP (addi x0, x0, 0) for the instruction word of IF/ID.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // IF/ID: pc, instruction word.
  localparam int unsigned IF_ID_W       = 64;
  localparam int unsigned IF_ID_INSTR_LSB = 0;
  localparam int unsigned IF_ID_PC_LSB    = 32;

  // ID/EX: pc, operand a, alu op, funct3, rd, reg write enable, mem read, immediate.
  localparam int unsigned ID_EX_W          = 114;
  localparam int unsigned ID_EX_IMM_LSB    = 0;
  localparam int unsigned ID_EX_MEM_RE_LSB = 32;
  localparam int unsigned ID_EX_REG_WE_LSB = 33;
  localparam int unsigned ID_EX_RD_LSB     = 34;
  localparam int unsigned ID_EX_FUNCT3_LSB = 39;
  localparam int unsigned ID_EX_ALU_OP_LSB = 42;
  localparam int unsigned ID_EX_OP_A_LSB   = 50;
  localparam int unsigned ID_EX_PC_LSB     = 82;

  // EX/MEM: alu result, store data, rd, reg write enable, mem read, mem write.
  localparam int unsigned EX_MEM_W = 72;

  // MEM/WB: write-back value, rd, reg write enable.
  localparam int unsigned MEM_WB_W = 38;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t f);
    return f;
  endfunction

  function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
    return v;
  endfunction

  function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t f);
    return f;
  endfunction

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
    return v;
  endfunction

  function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t f);
    return f;
  endfunction

  function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
    return v;
  endfunction

  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t f);
    return f;
  endfunction

  function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
    return v;
  endfunction

  // An ID/EX payload that decodes as a harmless no-op.
  function automatic logic [ID_EX_W-1:0] id_ex_nop();
    id_ex_t f;
    f        = '0;
    f.alu_op = alu_op_nop;
    return pack_id_ex(f);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; clear takes priority over increment.
module pipe_stage_reg_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MaxVal = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register: advance / hold / bubble / flush driven by the global
// stall vector, plus hold and bubble statistics and a sticky stall-protocol error flag.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W         = ID_EX_W,
  parameter int unsigned       STALL_W        = STALL_VEC_W,
  parameter int unsigned       STAGE          = 2,
  parameter logic [DATA_W-1:0] NOP_VAL        = '0,
  parameter logic              ZERO_ON_BUBBLE = ENABLE,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_counters,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [CNT_W-1:0]   hold_cycles,
  output logic [CNT_W-1:0]   bubble_count,
  output logic               proto_err
);

  if (STAGE + 1 >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic up, dn;
  logic kill;
  logic hold_inc, hold_clr;
  logic bubble_inc;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Flush and a plain upstream stall both drop the entry; only the stall counts as a bubble.
  assign kill       = flush || (up && !dn);
  assign bubble_inc = !flush && up && !dn;
  assign hold_inc   = !flush && dn && valid_q;
  assign hold_clr   = !hold_inc;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (kill) begin
      valid_d = 1'b0;
      if (ZERO_ON_BUBBLE == ENABLE) begin
        data_d = NOP_VAL;
      end
    end else if (!dn) begin
      valid_d = in_valid;
      if (!in_valid && (ZERO_ON_BUBBLE == ENABLE)) begin
        data_d = NOP_VAL;
      end else begin
        data_d = in_data;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_counters) begin
      err_d = DISABLE;
    end else if (!up && dn) begin
      err_d = ENABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= NOP_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  pipe_stage_reg_sat_counter #(
    .W (CNT_W)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hold_inc),
    .clr (hold_clr),
    .q   (hold_cycles)
  );

  pipe_stage_reg_sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .clr (clr_counters),
    .q   (bubble_count)
  );

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign proto_err = err_q;

endmodule
